alu_issue: RTL and testbench

Sequencing front-end that drives the combinational ALU: accepts one instruction at a time over a valid/ready handshake and reads operands from a small internal register file. It presents registered operands and opcode to the ALU, then samples the ALU result and flags and writes the result back. It returns the result and a flag snapshot over a second valid/ready handshake. It sits between the instruction source (decoder or test harness) and the ALU datapath.

---
 rtl/alu_issue_pkg.sv | 29 ++
 rtl/alu_regfile.sv | 38 +++
 rtl/alu_issue.sv | 128 ++++++++++++
 tb/tb_alu_issue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue front-end: opcodes, FSM states, flag bit positions.
package alu_issue_pkg;

    localparam logic [6:0] MATH_ADD = 7'h00;
    localparam logic [6:0] MATH_SUB = 7'h01;
    localparam logic [6:0] MATH_AND = 7'h02;
    localparam logic [6:0] MATH_IOR = 7'h03;
    localparam logic [6:0] MATH_XOR = 7'h04;
    localparam logic [6:0] MATH_CMP = 7'h05;
    localparam logic [6:0] MATH_MUL = 7'h06;
    localparam logic [6:0] MATH_DIV = 7'h07;
    localparam logic [6:0] MATH_MOD = 7'h08;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issue_state_e;

    // Bit positions inside the 7-bit flag vector {carry,equal,lt,zero,one,ovf,undef}
    localparam int FLAG_CARRY = 6;
    localparam int FLAG_EQUAL = 5;
    localparam int FLAG_LT    = 4;
    localparam int FLAG_ZERO  = 3;
    localparam int FLAG_ONE   = 2;
    localparam int FLAG_OVF   = 1;
    localparam int FLAG_UNDEF = 0;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x 8 register file: two operand read ports, one debug read port, one write port.
// r0 always reads zero and ignores writes; active-low synchronous clear.
module alu_regfile
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 4,
    localparam int RW = $clog2(NREGS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [RW-1:0] i_ra_addr,
    output logic [7:0]    o_ra_data,
    input  logic [RW-1:0] i_rb_addr,
    output logic [7:0]    o_rb_data,
    input  logic [RW-1:0] i_dbg_addr,
    output logic [7:0]    o_dbg_data,
    input  logic          i_we,
    input  logic [RW-1:0] i_wa,
    input  logic [7:0]    i_wd
);

    logic [7:0] regs_q [NREGS];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            regs_q[i_wa] <= i_wd;
        end
    end

    assign o_ra_data  = (i_ra_addr  == '0) ? 8'd0 : regs_q[i_ra_addr];
    assign o_rb_data  = (i_rb_addr  == '0) ? 8'd0 : regs_q[i_rb_addr];
    assign o_dbg_data = (i_dbg_addr == '0) ? 8'd0 : regs_q[i_dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue/sequencing front-end for the combinational ALU: IDLE -> EXEC -> RESP.
// Optional sticky divide-by-zero trap enabled by defining ALU_ISSUE_TRAP_EN.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int NREGS = 4,
    localparam int RW = $clog2(NREGS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [6:0]    i_op,
    input  logic          i_signed,
    input  logic [RW-1:0] i_rd,
    input  logic [RW-1:0] i_ra,
    input  logic [RW-1:0] i_rb,
    input  logic          i_use_imm,
    input  logic [7:0]    i_imm,
    output logic [7:0]    o_alu_a,
    output logic [7:0]    o_alu_b,
    output logic [6:0]    o_alu_op,
    output logic          o_alu_signed,
    input  logic [7:0]    i_alu_g,
    input  logic [6:0]    i_alu_flags,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [7:0]    o_res,
    output logic [6:0]    o_flags,
    input  logic [RW-1:0] i_dbg_addr,
    output logic [7:0]    o_dbg_data,
    output logic          o_trap,
    input  logic          i_trap_clr
);

    // Valid/ready: an instruction transfers on a rising edge with i_valid & o_ready,
    // a result transfers with o_res_valid & i_res_ready; neither side may retract
    // or change its payload while waiting.

    issue_state_e  state_q;
    logic [RW-1:0] rd_q;
    logic [7:0]    alu_a_q, alu_b_q, res_q;
    logic [6:0]    alu_op_q, flags_q;
    logic          alu_signed_q;
    logic [7:0]    ra_data, rb_data;
    logic          wb_en;

    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ra_addr  (i_ra),
        .o_ra_data  (ra_data),
        .i_rb_addr  (i_rb),
        .o_rb_data  (rb_data),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data),
        .i_we       (wb_en),
        .i_wa       (rd_q),
        .i_wd       (i_alu_g)
    );

`ifdef ALU_ISSUE_TRAP_EN
    logic trap_q;
    // A divide/modulo by zero must not corrupt the destination register
    assign wb_en  = (state_q == ST_EXEC) && (alu_op_q != MATH_CMP) && !i_alu_flags[FLAG_UNDEF];
    assign o_trap = trap_q;
`else
    logic unused_trap_clr;
    assign wb_en           = (state_q == ST_EXEC) && (alu_op_q != MATH_CMP);
    assign o_trap          = 1'b0;
    assign unused_trap_clr = i_trap_clr;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            rd_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_signed_q <= 1'b0;
            res_q        <= '0;
            flags_q      <= '0;
`ifdef ALU_ISSUE_TRAP_EN
            trap_q       <= 1'b0;
`endif
        end else begin
`ifdef ALU_ISSUE_TRAP_EN
            if (i_trap_clr) trap_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        rd_q         <= i_rd;
                        alu_op_q     <= i_op;
                        alu_signed_q <= i_signed;
                        alu_a_q      <= ra_data;
                        alu_b_q      <= i_use_imm ? i_imm : rb_data;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_q   <= i_alu_g;
                    flags_q <= i_alu_flags;
`ifdef ALU_ISSUE_TRAP_EN
                    // Placed after the clear so a same-cycle set wins
                    if (i_alu_flags[FLAG_UNDEF]) trap_q <= 1'b1;
`endif
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_res_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ready      = (state_q == ST_IDLE);
    assign o_res_valid  = (state_q == ST_RESP);
    assign o_alu_a      = alu_a_q;
    assign o_alu_b      = alu_b_q;
    assign o_alu_op     = alu_op_q;
    assign o_alu_signed = alu_signed_q;
    assign o_res        = res_q;
    assign o_flags      = flags_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU, reference register file, result scoreboard.
module tb_alu_issue;
    import alu_issue_pkg::*;

    localparam int NREGS = 4;
    localparam int RW    = 2;

    logic          clk = 1'b0;
    logic          i_rst_n, i_valid, i_signed, i_use_imm, i_res_ready, i_trap_clr;
    logic [6:0]    i_op;
    logic [RW-1:0] i_rd, i_ra, i_rb, i_dbg_addr;
    logic [7:0]    i_imm;
    logic          o_ready, o_alu_signed, o_res_valid, o_trap;
    logic [7:0]    o_alu_a, o_alu_b, o_res, o_dbg_data, alu_g;
    logic [6:0]    o_alu_op, o_flags, alu_flags;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [14:0]   exp_q[$];
    logic [7:0]    ref_q [NREGS];

    always #5 clk = ~clk;

    alu_issue #(.NREGS(NREGS)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_signed(i_signed), .i_rd(i_rd), .i_ra(i_ra), .i_rb(i_rb),
        .i_use_imm(i_use_imm), .i_imm(i_imm),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_alu_signed(o_alu_signed),
        .i_alu_g(alu_g), .i_alu_flags(alu_flags),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res(o_res), .o_flags(o_flags),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data),
        .o_trap(o_trap), .i_trap_clr(i_trap_clr)
    );

    // Behavioural ALU: returns {flags[6:0], g[7:0]}
    function automatic logic [14:0] alu_model(input logic [6:0] op, input logic s,
                                              input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  sum;
        logic [15:0] prod;
        logic [7:0]  g;
        logic        c, ov, u, lt;
        sum = '0; prod = '0; g = '0; c = 1'b0; ov = 1'b0; u = 1'b0;
        case (op)
            MATH_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                g = sum[7:0]; c = sum[8];
                ov = (a[7] == b[7]) && (g[7] != a[7]);
            end
            MATH_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                g = sum[7:0]; c = sum[8];
                ov = (a[7] != b[7]) && (g[7] != a[7]);
            end
            MATH_AND: g = a & b;
            MATH_IOR: g = a | b;
            MATH_XOR: g = a ^ b;
            MATH_CMP: g = a;
            MATH_MUL: begin
                prod = {8'd0, a} * {8'd0, b};
                g = prod[7:0]; c = |prod[15:8];
            end
            MATH_DIV: if (b == 8'd0) u = 1'b1; else g = a / b;
            MATH_MOD: if (b == 8'd0) u = 1'b1; else g = a % b;
            default:  g = 8'd0;
        endcase
        lt = s ? ($signed(a) < $signed(b)) : (a < b);
        return {c, (a == b), lt, (g == 8'd0), (g == 8'd1), (ov & s), u, g};
    endfunction

    always_comb {alu_flags, alu_g} = alu_model(o_alu_op, o_alu_signed, o_alu_a, o_alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic s, input int rd, input int ra,
                         input int rb, input logic ui, input logic [7:0] imm);
        logic [7:0]  a, b;
        logic [14:0] r;
        int          w;
        @(negedge clk);
        w = 0;
        while (!o_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_issue", {31'd0, o_ready}, 32'd1);
        a = ref_q[ra];
        b = ui ? imm : ref_q[rb];
        r = alu_model(op, s, a, b);
        exp_q.push_back(r);
        if (rd != 0 && op != MATH_CMP) begin
`ifdef ALU_ISSUE_TRAP_EN
            if (!r[8]) ref_q[rd] = r[7:0];
`else
            ref_q[rd] = r[7:0];
`endif
        end
        i_op = op; i_signed = s; i_rd = rd[RW-1:0]; i_ra = ra[RW-1:0]; i_rb = rb[RW-1:0];
        i_use_imm = ui; i_imm = imm; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("ready_low_exec", {31'd0, o_ready}, 32'd0);
        check("alu_a", {24'd0, o_alu_a}, {24'd0, a});
        check("alu_b", {24'd0, o_alu_b}, {24'd0, b});
        check("alu_op", {25'd0, o_alu_op}, {25'd0, op});
    endtask

    task automatic collect(input int rd, input int hold);
        int          lat;
        logic [14:0] e;
        lat = 0;
        while (!o_res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("res_latency", lat, 32'd1);
        check("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 15'd0;
        check("res", {24'd0, o_res}, {24'd0, e[7:0]});
        check("flags", {25'd0, o_flags}, {25'd0, e[14:8]});
        i_dbg_addr = rd[RW-1:0];
        #1;
        check("writeback", {24'd0, o_dbg_data}, {24'd0, ref_q[rd]});
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'b1; i_op = MATH_XOR; i_rd = 2'd1; i_use_imm = 1'b1; i_imm = 8'hFF;
            @(posedge clk); #1;
            check("hold_res", {24'd0, o_res}, {24'd0, e[7:0]});
            check("hold_flags", {25'd0, o_flags}, {25'd0, e[14:8]});
            check("hold_valid", {31'd0, o_res_valid}, 32'd1);
            check("hold_ready", {31'd0, o_ready}, 32'd0);
        end
        i_valid = 1'b0;
        i_res_ready = 1'b1;
        @(posedge clk); #1;
        i_res_ready = 1'b0;
        check("res_valid_drop", {31'd0, o_res_valid}, 32'd0);
        check("ready_after", {31'd0, o_ready}, 32'd1);
    endtask

    task automatic reset_ref();
        for (int i = 0; i < NREGS; i++) ref_q[i] = 8'd0;
    endtask

    logic [6:0] ops [9];

    initial begin
        ops = '{MATH_ADD, MATH_SUB, MATH_AND, MATH_IOR, MATH_XOR, MATH_CMP, MATH_MUL, MATH_DIV, MATH_MOD};
        i_rst_n = 1'b0; i_valid = 1'b0; i_signed = 1'b0; i_use_imm = 1'b0; i_res_ready = 1'b0;
        i_trap_clr = 1'b0; i_op = '0; i_rd = '0; i_ra = '0; i_rb = '0; i_imm = '0; i_dbg_addr = '0;
        reset_ref();

        // Clock/reset
        repeat (3) @(posedge clk);
        #1 i_rst_n = 1'b1;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_res_valid", {31'd0, o_res_valid}, 32'd0);
        check("rst_trap", {31'd0, o_trap}, 32'd0);
        check("rst_res", {24'd0, o_res}, 32'd0);
        check("rst_flags", {25'd0, o_flags}, 32'd0);
        check("rst_alu_a", {24'd0, o_alu_a}, 32'd0);
        check("rst_alu_op", {25'd0, o_alu_op}, 32'd0);
        for (int i = 0; i < NREGS; i++) begin
            i_dbg_addr = i[RW-1:0];
            #1 check("rst_reg", {24'd0, o_dbg_data}, 32'd0);
        end

        // Directed program: r1=200, r2=100, r3=r1+r2 (44, carry), CMP, DIV by zero
        issue(MATH_IOR, 1'b0, 1, 0, 0, 1'b1, 8'd200); collect(1, 0);
        issue(MATH_IOR, 1'b0, 2, 0, 0, 1'b1, 8'd100); collect(2, 0);
        issue(MATH_ADD, 1'b0, 3, 1, 2, 1'b0, 8'd0);   collect(3, 0);
        check("add_r3_is_44", {24'd0, o_dbg_data}, 32'd44);
        issue(MATH_CMP, 1'b0, 3, 1, 2, 1'b0, 8'd0);   collect(3, 0);
        issue(MATH_DIV, 1'b0, 3, 1, 0, 1'b1, 8'd0);   collect(3, 0);
`ifdef ALU_ISSUE_TRAP_EN
        check("trap_set", {31'd0, o_trap}, 32'd1);
        repeat (2) @(posedge clk);
        #1 check("trap_sticky", {31'd0, o_trap}, 32'd1);
        @(negedge clk) i_trap_clr = 1'b1;
        @(posedge clk); #1 i_trap_clr = 1'b0;
        check("trap_cleared", {31'd0, o_trap}, 32'd0);
`else
        check("trap_tied", {31'd0, o_trap}, 32'd0);
`endif

        // Backpressure with ignored i_valid, unknown opcode, dependent operations
        issue(MATH_SUB, 1'b1, 1, 1, 2, 1'b0, 8'd0);   collect(1, 5);
        issue(7'h7F, 1'b0, 2, 1, 1, 1'b0, 8'd0);      collect(2, 0);
        issue(MATH_ADD, 1'b0, 2, 1, 1, 1'b0, 8'd0);   collect(2, 0);
        issue(MATH_ADD, 1'b0, 0, 1, 0, 1'b1, 8'd9);   collect(0, 0);
        for (int k = 0; k < 10; k++) begin
            int rd, ra, rb;
            rd = $urandom_range(0, NREGS - 1);
            ra = $urandom_range(0, NREGS - 1);
            rb = $urandom_range(0, NREGS - 1);
            issue(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), rd, ra, rb,
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            collect(rd, $urandom_range(0, 2));
        end

        // Reset while the write to r2 is in EXEC
        issue(MATH_IOR, 1'b0, 2, 0, 0, 1'b1, 8'd77);
        i_rst_n = 1'b0;
        @(posedge clk); #1 i_rst_n = 1'b1;
        void'(exp_q.pop_front());
        reset_ref();
        i_dbg_addr = 2'd2;
        #1 check("rst_exec_r2", {24'd0, o_dbg_data}, 32'd0);
        check("rst_exec_ready", {31'd0, o_ready}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("rst_exec_no_res", {31'd0, o_res_valid}, 32'd0);
        end
        issue(MATH_ADD, 1'b0, 1, 2, 0, 1'b1, 8'd5); collect(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
